// File: rtl/instr_queue_pkg.sv
// Shared widths, constants and fetch FSM encodings for the instruction queue.
package instr_queue_pkg;
  localparam int PcLength    = 32;
  localparam int InstrLength = 32;
  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;
  localparam logic [6:0] JalOpcode = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // JAL target: pc + sign-extended J-immediate.
  function automatic logic [PcLength-1:0] jal_target(input logic [PcLength-1:0] pc,
                                                     input logic [InstrLength-1:0] instr);
    logic [20:0] imm;
    imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    return pc + {{(PcLength-21){imm[20]}}, imm};
  endfunction
endpackage

// File: rtl/instr_queue_if.sv
// Fetch-side bus: memory request/response, decoder head view, and ROB redirect.
interface instr_queue_if;
  import instr_queue_pkg::*;

  // Handshakes: is_fetch_to_mem/addr_to_mem stay asserted until the one-cycle
  // is_done_from_mem strobe (instr_from_mem valid with it); the decoder takes
  // the head in any cycle where !is_empty_to_dc && !is_stall_from_dispatch.
  logic                   is_stall_from_dispatch;
  logic                   is_jump_from_rob;
  logic [PcLength-1:0]    pc_jump_from_rob;
  logic                   is_fetch_to_mem;
  logic [PcLength-1:0]    addr_to_mem;
  logic                   is_done_from_mem;
  logic [InstrLength-1:0] instr_from_mem;
  logic                   is_empty_to_dc;
  logic [PcLength-1:0]    pc_to_dc;
  logic [InstrLength-1:0] instr_to_dc;

  modport master (
    input  is_stall_from_dispatch, is_jump_from_rob, pc_jump_from_rob,
    input  is_done_from_mem, instr_from_mem,
    output is_fetch_to_mem, addr_to_mem,
    output is_empty_to_dc, pc_to_dc, instr_to_dc
  );

  modport slave (
    output is_stall_from_dispatch, is_jump_from_rob, pc_jump_from_rob,
    output is_done_from_mem, instr_from_mem,
    input  is_fetch_to_mem, addr_to_mem,
    input  is_empty_to_dc, pc_to_dc, instr_to_dc
  );
endinterface

// File: rtl/instr_queue_fifo.sv
// Circular buffer of {pc, instr} pairs with flush; head view reads 0 when empty.
module instr_fifo
  import instr_queue_pkg::*;
#(
  parameter int Depth      = 16,
  parameter int AddrLength = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [PcLength-1:0]    push_pc,
  input  logic [InstrLength-1:0] push_instr,
  output logic [PcLength-1:0]    head_pc,
  output logic [InstrLength-1:0] head_instr,
  output logic                   full,
  output logic                   empty
);
  localparam logic [AddrLength:0] DepthCount = (AddrLength+1)'(Depth);

  logic [PcLength-1:0]    pc_mem    [Depth];
  logic [InstrLength-1:0] instr_mem [Depth];
  logic [AddrLength-1:0]  head;
  logic [AddrLength-1:0]  tail;
  logic [AddrLength:0]    count;

  assign empty      = (count == '0);
  assign full       = (count == DepthCount);
  assign head_pc    = empty ? '0 : pc_mem[head];
  assign head_instr = empty ? '0 : instr_mem[head];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // Pointers are exactly log2(Depth) wide, so increment wraps on its own.
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      pc_mem[tail]    <= push_pc;
      instr_mem[tail] <= push_instr;
    end
  end
endmodule

// File: rtl/instr_queue.sv
// Fetch PC, single-outstanding memory fetch FSM and decoder-facing queue.
// Define JAL_PREDICT_EN to redirect fetch to JAL targets as they are enqueued.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int                  QueueDepth      = 16,
  parameter int                  QueueAddrLength = 4,
  parameter logic [PcLength-1:0] ResetPc         = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  instr_queue_if.master        bus,
  output fetch_state_e         fsm_state
);
  fetch_state_e        state_q, state_d;
  logic                req_q, req_d;
  logic [PcLength-1:0] addr_q, addr_d;
  logic [PcLength-1:0] fetch_pc_q, fetch_pc_d;
  logic [PcLength-1:0] next_pc;
  logic                jump, done, push, pop, flush;
  logic                full, empty;

  assign jump  = bus.is_jump_from_rob;
  assign done  = bus.is_done_from_mem;
  assign push  = rdy && (state_q == WAIT) && done && !jump;
  assign pop   = rdy && !empty && !bus.is_stall_from_dispatch && !jump;
  assign flush = rdy && jump;

`ifdef JAL_PREDICT_EN
  assign next_pc = (bus.instr_from_mem[6:0] == JalOpcode)
                   ? jal_target(fetch_pc_q, bus.instr_from_mem)
                   : fetch_pc_q + 32'd4;
`else
  assign next_pc = fetch_pc_q + 32'd4;
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    if (push) fetch_pc_d = next_pc;
    if (jump) fetch_pc_d = bus.pc_jump_from_rob;
    case (state_q)
      IDLE: begin
        if (!jump && !full) begin
          state_d = WAIT;
          req_d   = True;
          addr_d  = fetch_pc_q;
        end
      end
      WAIT: begin
        // A jump with the response already here has nothing left to discard.
        if (jump) begin
          req_d   = False;
          state_d = done ? IDLE : DISCARD;
        end else if (done) begin
          req_d   = False;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        req_d = False;
        if (done) state_d = IDLE;
      end
      default: begin
        req_d   = False;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= False;
      addr_q     <= '0;
      fetch_pc_q <= ResetPc;
    end else if (rdy) begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  instr_fifo #(
    .Depth      (QueueDepth),
    .AddrLength (QueueAddrLength)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_pc    (fetch_pc_q),
    .push_instr (bus.instr_from_mem),
    .head_pc    (bus.pc_to_dc),
    .head_instr (bus.instr_to_dc),
    .full       (full),
    .empty      (empty)
  );

  assign bus.is_fetch_to_mem = req_q;
  assign bus.addr_to_mem     = addr_q;
  assign bus.is_empty_to_dc  = empty;
  assign fsm_state           = state_q;
endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: fetch flow, full queue, flush, rdy freeze, JAL redirect.
module tb_instr_queue;
  import instr_queue_pkg::*;

  logic         clk;
  logic         rst;
  logic         rdy;
  fetch_state_e fsm_state;
  int           n_checks;
  int           n_fail;

  instr_queue_if bus();

  instr_queue dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (bus.is_fetch_to_mem !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check("req_seen", 32'(bus.is_fetch_to_mem), 32'd1);
  endtask

  task automatic respond(input int lat, input logic [31:0] word);
    repeat (lat) tick();
    bus.is_done_from_mem = 1'b1;
    bus.instr_from_mem   = word;
    tick();
    bus.is_done_from_mem = 1'b0;
    bus.instr_from_mem   = '0;
  endtask

  initial begin
    logic [31:0] jal_exp;
    n_checks = 0;
    n_fail   = 0;
    bus.is_stall_from_dispatch = 1'b0;
    bus.is_jump_from_rob       = 1'b0;
    bus.pc_jump_from_rob       = '0;
    bus.is_done_from_mem       = 1'b0;
    bus.instr_from_mem         = '0;

    // Reset with rdy low: reset must still win.
    rst = 1'b1;
    rdy = 1'b0;
    tick();
    tick();
    check("rst_req",   32'(bus.is_fetch_to_mem), 32'd0);
    check("rst_addr",  bus.addr_to_mem, 32'd0);
    check("rst_empty", 32'(bus.is_empty_to_dc), 32'd1);
    check("rst_pc",    bus.pc_to_dc, 32'd0);
    check("rst_instr", bus.instr_to_dc, 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    rdy = 1'b1;
    tick();
    rst = 1'b0;

    // 1: sequential fetch, decoder never stalls
    for (int i = 0; i < 3; i++) begin
      wait_req();
      check("t1_addr", bus.addr_to_mem, 32'(4 * i));
      respond(3, 32'h0000_0013);
      check("t1_empty_lo", 32'(bus.is_empty_to_dc), 32'd0);
      check("t1_pc",       bus.pc_to_dc, 32'(4 * i));
      check("t1_instr",    bus.instr_to_dc, 32'h0000_0013);
      tick();
      check("t1_empty_hi", 32'(bus.is_empty_to_dc), 32'd1);
    end

    // 2: fill all 16 entries under stall, then drain across the wrap
    bus.is_stall_from_dispatch = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_req();
      check("t2_addr", bus.addr_to_mem, 32'(12 + 4 * i));
      respond(1, 32'hA000_0000 | 32'(i));
    end
    for (int i = 0; i < 4; i++) begin
      check("t2_full_noreq", 32'(bus.is_fetch_to_mem), 32'd0);
      tick();
    end
    check("t2_full_head", bus.pc_to_dc, 32'd12);
    bus.is_stall_from_dispatch = 1'b0;
    check("t2_pop_pc0", bus.pc_to_dc, 32'd12);
    check("t2_pop_in0", bus.instr_to_dc, 32'hA000_0000);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("t2_pop_pc", bus.pc_to_dc, 32'(12 + 4 * i));
      check("t2_pop_in", bus.instr_to_dc, 32'hA000_0000 | 32'(i));
    end
    tick();
    check("t2_drained", 32'(bus.is_empty_to_dc), 32'd1);
    check("t2_resume_req",  32'(bus.is_fetch_to_mem), 32'd1);
    check("t2_resume_addr", bus.addr_to_mem, 32'd76);
    respond(1, 32'h0000_0013);
    check("t2_after_wrap_pc", bus.pc_to_dc, 32'd76);
    tick();
    wait_req();
    check("t3_pre_addr", bus.addr_to_mem, 32'd80);

    // 3: jump while WAIT, stale response arrives two cycles later
    bus.is_jump_from_rob = 1'b1;
    bus.pc_jump_from_rob = 32'h0000_1000;
    tick();
    bus.is_jump_from_rob = 1'b0;
    check("t3_req_drop", 32'(bus.is_fetch_to_mem), 32'd0);
    check("t3_discard",  32'(fsm_state), 32'(DISCARD));
    check("t3_empty",    32'(bus.is_empty_to_dc), 32'd1);
    tick();
    bus.is_done_from_mem = 1'b1;
    bus.instr_from_mem   = 32'hDEAD_BEEF;
    tick();
    bus.is_done_from_mem = 1'b0;
    bus.instr_from_mem   = '0;
    check("t3_stale_dropped", 32'(bus.is_empty_to_dc), 32'd1);
    check("t3_idle",          32'(fsm_state), 32'(IDLE));
    wait_req();
    check("t3_target", bus.addr_to_mem, 32'h0000_1000);
    check("t3_still_empty", 32'(bus.is_empty_to_dc), 32'd1);

    // 4: jump together with done and a would-be pop
    bus.is_stall_from_dispatch = 1'b1;
    respond(2, 32'h0000_0013);
    check("t4_entry_pc", bus.pc_to_dc, 32'h0000_1000);
    tick();
    check("t4_req",  32'(bus.is_fetch_to_mem), 32'd1);
    check("t4_addr", bus.addr_to_mem, 32'h0000_1004);
    bus.is_stall_from_dispatch = 1'b0;
    bus.is_done_from_mem       = 1'b1;
    bus.instr_from_mem         = 32'hBAD0_BAD0;
    bus.is_jump_from_rob       = 1'b1;
    bus.pc_jump_from_rob       = 32'h0000_2000;
    tick();
    bus.is_done_from_mem = 1'b0;
    bus.instr_from_mem   = '0;
    bus.is_jump_from_rob = 1'b0;
    check("t4_empty", 32'(bus.is_empty_to_dc), 32'd1);
    check("t4_pc0",   bus.pc_to_dc, 32'd0);
    check("t4_in0",   bus.instr_to_dc, 32'd0);
    check("t4_idle",  32'(fsm_state), 32'(IDLE));
    check("t4_noreq", 32'(bus.is_fetch_to_mem), 32'd0);
    wait_req();
    check("t4_target", bus.addr_to_mem, 32'h0000_2000);
    check("t4_no_write", 32'(bus.is_empty_to_dc), 32'd1);

    // 5: rdy low for 5 cycles mid-WAIT, done during freeze is ignored
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.is_done_from_mem = (i == 2);
      bus.instr_from_mem   = 32'h00BA_DBAD;
      tick();
      check("t5_req",   32'(bus.is_fetch_to_mem), 32'd1);
      check("t5_addr",  bus.addr_to_mem, 32'h0000_2000);
      check("t5_empty", 32'(bus.is_empty_to_dc), 32'd1);
      check("t5_state", 32'(fsm_state), 32'(WAIT));
    end
    bus.is_done_from_mem = 1'b0;
    bus.instr_from_mem   = '0;
    rdy = 1'b1;
    tick();
    check("t5_req_held",   32'(bus.is_fetch_to_mem), 32'd1);
    check("t5_still_empty", 32'(bus.is_empty_to_dc), 32'd1);
    respond(1, 32'h0000_0013);
    check("t5_pc", bus.pc_to_dc, 32'h0000_2000);

    // 6: JAL at pc 0x10 (jal x0, +0x100)
    bus.is_jump_from_rob = 1'b1;
    bus.pc_jump_from_rob = 32'h0000_0010;
    tick();
    bus.is_jump_from_rob = 1'b0;
    check("t6_flush_empty", 32'(bus.is_empty_to_dc), 32'd1);
    check("t6_noreq",       32'(bus.is_fetch_to_mem), 32'd0);
    wait_req();
    check("t6_addr", bus.addr_to_mem, 32'h0000_0010);
    respond(1, 32'h1000_006F);
    check("t6_pc",    bus.pc_to_dc, 32'h0000_0010);
    check("t6_instr", bus.instr_to_dc, 32'h1000_006F);
`ifdef JAL_PREDICT_EN
    jal_exp = 32'h0000_0110;
`else
    jal_exp = 32'h0000_0014;
`endif
    wait_req();
    check("t6_next_addr", bus.addr_to_mem, jal_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
